// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues word fetches to instruction memory and
// buffers in-order responses with their PCs for the decode stage.
// A credit check stops new requests while outstanding requests plus
// buffered entries already fill the buffer. Because of this, responses
// never need backpressure. A redirect flushes the buffer and marks every
// request still in flight as stale, so its response is dropped on arrival.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   imem_req_*          fetch request channel (valid/ready, byte address)
//   imem_rsp_*          in-order fetch responses, always accepted
//   redirect_*          branch/jump redirect with new PC
//   if_valid/if_ready   decode handshake
//   if_instr/if_pc      buffer head, NOP_INSTR/0 when the buffer is empty
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned SUM_W = CNT_W + 1;

    logic [31:0]      fetch_pc;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] discard;
    logic [CNT_W-1:0] fifo_count;
    logic [PTR_W-1:0] fifo_wr_ptr;
    logic [PTR_W-1:0] fifo_rd_ptr;
    logic [PTR_W-1:0] pcq_wr_ptr;
    logic [PTR_W-1:0] pcq_rd_ptr;
    logic [31:0]      fifo_instr [FIFO_DEPTH];
    logic [31:0]      fifo_pc    [FIFO_DEPTH];
    logic [31:0]      pcq_pc     [FIFO_DEPTH];

    logic [SUM_W-1:0] credit_used;
    logic             req_fire;
    logic             rsp_drop;
    logic             fifo_push;
    logic             fifo_pop;
    logic [1:0]       unused_redirect_lsb;

    assign unused_redirect_lsb = redirect_pc[1:0];

    // Request credit, handshake qualifiers and decode-side view of the buffer head
    always_comb begin
        credit_used    = SUM_W'(outstanding) + SUM_W'(fifo_count);
        imem_req_valid = !rst && !redirect_valid && (credit_used < SUM_W'(FIFO_DEPTH));
        imem_req_addr  = fetch_pc;
        req_fire       = imem_req_valid && imem_req_ready;
        rsp_drop       = imem_rsp_valid && (discard != '0);
        // A response landing in a redirect cycle is stale even if discard is zero
        fifo_push      = imem_rsp_valid && (discard == '0) && !redirect_valid;
        if_valid       = (fifo_count != '0);
        fifo_pop       = if_valid && if_ready && !redirect_valid;
        if_instr       = NOP_INSTR;
        if_pc          = 32'h0;
        if (if_valid) begin
            if_instr = fifo_instr[fifo_rd_ptr];
            if_pc    = fifo_pc[fifo_rd_ptr];
        end
    end

    // Fetch PC, credit counters and buffer pointers
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
            fifo_count  <= '0;
            fifo_wr_ptr <= '0;
            fifo_rd_ptr <= '0;
            pcq_wr_ptr  <= '0;
            pcq_rd_ptr  <= '0;
        end else begin
            if (redirect_valid) begin
                fetch_pc <= {redirect_pc[31:2], 2'b00};
            end else if (req_fire) begin
                fetch_pc <= fetch_pc + 32'd4;
            end

            outstanding <= outstanding + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);

            // After a redirect every request still in flight is stale, and that
            // includes requests that were already marked stale earlier
            if (redirect_valid) begin
                discard <= outstanding - CNT_W'(imem_rsp_valid);
            end else begin
                discard <= discard - CNT_W'(rsp_drop);
            end

            // PC queue tracks every in-flight request, stale or not
            if (req_fire) begin
                pcq_wr_ptr <= pcq_wr_ptr + PTR_W'(1);
            end
            if (imem_rsp_valid) begin
                pcq_rd_ptr <= pcq_rd_ptr + PTR_W'(1);
            end

            if (redirect_valid) begin
                fifo_count  <= '0;
                fifo_wr_ptr <= '0;
                fifo_rd_ptr <= '0;
            end else begin
                fifo_count <= fifo_count + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
                if (fifo_push) begin
                    fifo_wr_ptr <= fifo_wr_ptr + PTR_W'(1);
                end
                if (fifo_pop) begin
                    fifo_rd_ptr <= fifo_rd_ptr + PTR_W'(1);
                end
            end
        end
    end

    // Storage arrays; contents are only meaningful under the counters above
    always_ff @(posedge clk) begin
        if (req_fire) begin
            pcq_pc[pcq_wr_ptr] <= fetch_pc;
        end
        if (fifo_push) begin
            fifo_instr[fifo_wr_ptr] <= imem_rsp_data;
            fifo_pc[fifo_wr_ptr]    <= pcq_pc[pcq_rd_ptr];
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit. It contains a latency-configurable
// in-order memory model and a scoreboard. The expected instruction/PC pair
// is queued when the memory returns a response from the current redirect
// epoch. It is compared when decode consumes an instruction.
module tb_instr_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int unsigned DEPTH    = 2;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data  = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc    = 32'h0;
    logic        if_valid;
    logic        if_ready = 1'b1;
    logic [31:0] if_instr;
    logic [31:0] if_pc;

    instr_fetch_unit #(
        .RESET_PC  (RESET_PC),
        .FIFO_DEPTH(DEPTH),
        .NOP_INSTR (NOP)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr (imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .if_valid      (if_valid),
        .if_ready      (if_ready),
        .if_instr      (if_instr),
        .if_pc         (if_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } mreq_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    mreq_t       mem_q[$];
    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          mem_lat = 1;
    int          epoch = 0;
    int          n_fire = 0;
    int          n_rsp = 0;
    int          n_pop = 0;
    bit          mon_en = 1'b0;
    logic [31:0] exp_req_addr = RESET_PC;
    logic [31:0] exp_out_pc = RESET_PC;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: present the oldest accepted request once its latency has elapsed
    always @(posedge clk) begin
        #1;
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_data(mem_q[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'hDEAD_BEEF;
        end
    end

    // Mid-cycle monitor: checks the outputs and applies the events of the coming edge to the model
    always @(negedge clk) begin : monitor
        mreq_t m;
        if (mon_en) begin
            n_cmp++;
            if (if_valid !== (sb.size() != 0)) begin
                n_bad++;
                $display("FAIL if_valid: got %b expected %b at %0t", if_valid, (sb.size() != 0), $time);
            end
            if (if_valid === 1'b1 && sb.size() != 0) begin
                n_cmp++;
                if (if_pc !== sb[0].pc || if_instr !== sb[0].data) begin
                    n_bad++;
                    $display("FAIL head: got pc=%h instr=%h expected pc=%h instr=%h at %0t",
                             if_pc, if_instr, sb[0].pc, sb[0].data, $time);
                end
            end else if (if_valid === 1'b0) begin
                n_cmp++;
                if (if_pc !== 32'h0 || if_instr !== NOP) begin
                    n_bad++;
                    $display("FAIL empty_out: got pc=%h instr=%h expected pc=0 instr=%h at %0t",
                             if_pc, if_instr, NOP, $time);
                end
            end

            if (rst) begin
                mem_q.delete();
                sb.delete();
                epoch++;
                exp_req_addr = RESET_PC;
                exp_out_pc   = RESET_PC;
            end else begin
                if (if_valid && if_ready && !redirect_valid) begin
                    n_cmp++;
                    if (if_pc !== exp_out_pc) begin
                        n_bad++;
                        $display("FAIL pc_order: got %h expected %h at %0t", if_pc, exp_out_pc, $time);
                    end
                    exp_out_pc = exp_out_pc + 32'd4;
                    if (sb.size() != 0) void'(sb.pop_front());
                    n_pop++;
                end
                if (imem_rsp_valid && mem_q.size() != 0) begin
                    m = mem_q.pop_front();
                    n_rsp++;
                    if (m.epoch == epoch && !redirect_valid)
                        sb.push_back('{pc: m.addr, data: mem_data(m.addr)});
                end
                if (imem_req_valid && imem_req_ready) begin
                    n_cmp++;
                    if (imem_req_addr !== exp_req_addr) begin
                        n_bad++;
                        $display("FAIL req_addr: got %h expected %h at %0t", imem_req_addr, exp_req_addr, $time);
                    end
                    mem_q.push_back('{addr: imem_req_addr, epoch: epoch, due: cyc + mem_lat});
                    exp_req_addr = exp_req_addr + 32'd4;
                    n_fire++;
                end
                if (redirect_valid) begin
                    sb.delete();
                    epoch++;
                    exp_req_addr = redirect_pc & ~32'h3;
                    exp_out_pc   = redirect_pc & ~32'h3;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic apply_reset(input int lat, input logic rdy, input logic ifr);
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        mem_lat        = lat;
        imem_req_ready = rdy;
        if_ready       = ifr;
        tick();
        tick();
        n_fire = 0;
        n_rsp  = 0;
        n_pop  = 0;
        rst    = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        mon_en = 1'b1;
        tick();
        @(negedge clk);
        n_cmp++;
        if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL rst_req_valid: got %b expected 0", imem_req_valid); end
        n_cmp++;
        if (if_valid !== 1'b0) begin n_bad++; $display("FAIL rst_if_valid: got %b expected 0", if_valid); end
        n_cmp++;
        if (if_instr !== NOP) begin n_bad++; $display("FAIL rst_if_instr: got %h expected %h", if_instr, NOP); end
        n_cmp++;
        if (if_pc !== 32'h0) begin n_bad++; $display("FAIL rst_if_pc: got %h expected 0", if_pc); end
        n_cmp++;
        if (imem_req_addr !== RESET_PC) begin n_bad++; $display("FAIL rst_req_addr: got %h expected %h", imem_req_addr, RESET_PC); end
        apply_reset(1, 1'b1, 1'b1);
    endtask

    task automatic test_free_run();
        bit found = 1'b0;
        int p0;
        for (int i = 0; i < 8 && !found; i++) begin
            @(negedge clk);
            if (if_valid === 1'b1) found = 1'b1;
        end
        n_cmp++;
        if (!found || if_pc !== RESET_PC || if_instr !== mem_data(RESET_PC)) begin
            n_bad++;
            $display("FAIL free_first: got valid=%b pc=%h expected valid=1 pc=%h", found, if_pc, RESET_PC);
        end
        // The credit limit allows at least one instruction every other cycle
        p0 = n_pop;
        repeat (30) @(negedge clk);
        n_cmp++;
        if (n_pop - p0 < 15) begin
            n_bad++;
            $display("FAIL free_throughput: got %0d pops expected >= 15", n_pop - p0);
        end
    endtask

    task automatic test_decode_stall();
        int p0;
        apply_reset(1, 1'b1, 1'b0);
        repeat (10) begin
            @(negedge clk);
            if (if_valid === 1'b1) begin
                n_cmp++;
                if (if_pc !== RESET_PC || if_instr !== mem_data(RESET_PC)) begin
                    n_bad++;
                    $display("FAIL stall_hold: got pc=%h instr=%h expected pc=%h instr=%h",
                             if_pc, if_instr, RESET_PC, mem_data(RESET_PC));
                end
            end
        end
        n_cmp++;
        if (n_fire != DEPTH || n_rsp != DEPTH) begin
            n_bad++;
            $display("FAIL stall_credit: got fires=%0d rsps=%0d expected %0d each", n_fire, n_rsp, DEPTH);
        end
        n_cmp++;
        if (imem_req_valid !== 1'b0 || if_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL stall_state: got req_valid=%b if_valid=%b expected 0/1", imem_req_valid, if_valid);
        end
        @(posedge clk);
        #2;
        if_ready = 1'b1;
        p0 = n_pop;
        repeat (12) @(negedge clk);
        n_cmp++;
        if (n_pop - p0 < DEPTH + 2) begin
            n_bad++;
            $display("FAIL stall_resume: got %0d pops expected >= %0d", n_pop - p0, DEPTH + 2);
        end
    endtask

    task automatic test_redirect_outstanding();
        bit found = 1'b0;
        apply_reset(3, 1'b1, 1'b1);
        for (int i = 0; i < 20 && !found; i++) begin
            if (mem_q.size() == 2 && imem_rsp_valid === 1'b0) found = 1'b1;
            else tick();
        end
        n_cmp++;
        if (!found) begin n_bad++; $display("FAIL redir_setup: got no 2-outstanding window expected one"); end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        tick();
        redirect_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            if (imem_req_valid === 1'b1 && imem_req_ready === 1'b1) found = 1'b1;
        end
        n_cmp++;
        if (!found || imem_req_addr !== 32'h100) begin
            n_bad++;
            $display("FAIL redir_req: got found=%b addr=%h expected addr=00000100", found, imem_req_addr);
        end
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            if (if_valid === 1'b1) found = 1'b1;
        end
        n_cmp++;
        if (!found || if_pc !== 32'h100 || if_instr !== mem_data(32'h100)) begin
            n_bad++;
            $display("FAIL redir_first: got found=%b pc=%h expected pc=00000100", found, if_pc);
        end
    endtask

    task automatic test_back_to_back();
        bit found = 1'b0;
        apply_reset(3, 1'b1, 1'b1);
        for (int i = 0; i < 20 && !found; i++) begin
            if (mem_q.size() == 2 && imem_rsp_valid === 1'b0) found = 1'b1;
            else tick();
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0400;
        tick();
        redirect_pc    = 32'h0000_0502;
        tick();
        redirect_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            if (if_valid === 1'b1) found = 1'b1;
        end
        n_cmp++;
        if (!found || if_pc !== 32'h500) begin
            n_bad++;
            $display("FAIL b2b_first: got found=%b pc=%h expected pc=00000500", found, if_pc);
        end
    endtask

    task automatic test_redirect_collide();
        bit found = 1'b0;
        apply_reset(2, 1'b1, 1'b1);
        for (int i = 0; i < 30 && !found; i++) begin
            if (imem_rsp_valid === 1'b1 && if_valid === 1'b1) found = 1'b1;
            else tick();
        end
        n_cmp++;
        if (!found) begin n_bad++; $display("FAIL collide_setup: got no rsp+pop cycle expected one"); end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        @(negedge clk);
        n_cmp++;
        if (imem_req_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL collide_req: got req_valid=%b expected 0", imem_req_valid);
        end
        @(posedge clk);
        #2;
        redirect_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (if_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL collide_flush: got if_valid=%b expected 0", if_valid);
        end
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            if (if_valid === 1'b1) found = 1'b1;
        end
        n_cmp++;
        if (!found || if_pc !== 32'h200) begin
            n_bad++;
            $display("FAIL collide_first: got found=%b pc=%h expected pc=00000200", found, if_pc);
        end
    endtask

    task automatic test_req_stall();
        bit found = 1'b0;
        apply_reset(1, 1'b0, 1'b1);
        repeat (5) begin
            @(negedge clk);
            n_cmp++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC) begin
                n_bad++;
                $display("FAIL req_hold: got valid=%b addr=%h expected valid=1 addr=%h",
                         imem_req_valid, imem_req_addr, RESET_PC);
            end
        end
        @(posedge clk);
        #2;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0803;
        @(negedge clk);
        n_cmp++;
        if (imem_req_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL req_retract: got valid=%b expected 0", imem_req_valid);
        end
        @(posedge clk);
        #2;
        redirect_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h800) begin
            n_bad++;
            $display("FAIL req_new: got valid=%b addr=%h expected valid=1 addr=00000800", imem_req_valid, imem_req_addr);
        end
        @(posedge clk);
        #2;
        imem_req_ready = 1'b1;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (if_valid === 1'b1) found = 1'b1;
        end
        n_cmp++;
        if (!found || if_pc !== 32'h800) begin
            n_bad++;
            $display("FAIL req_first: got found=%b pc=%h expected pc=00000800", found, if_pc);
        end
    endtask

    task automatic test_wrap_and_reset();
        int          nf = 0;
        logic [31:0] a0 = 32'h1;
        logic [31:0] a1 = 32'h1;
        bit          found = 1'b0;
        apply_reset(1, 1'b1, 1'b1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        for (int i = 0; i < 20 && nf < 2; i++) begin
            @(negedge clk);
            if (imem_req_valid === 1'b1 && imem_req_ready === 1'b1) begin
                if (nf == 0) a0 = imem_req_addr;
                else a1 = imem_req_addr;
                nf++;
            end
        end
        n_cmp++;
        if (nf != 2 || a0 !== 32'hFFFF_FFFC || a1 !== 32'h0) begin
            n_bad++;
            $display("FAIL wrap: got n=%0d a0=%h a1=%h expected n=2 a0=fffffffc a1=00000000", nf, a0, a1);
        end
        repeat (6) @(negedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (if_valid !== 1'b0 || imem_req_addr !== RESET_PC || imem_req_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_rst: got if_valid=%b addr=%h req_valid=%b expected 0/%h/1",
                     if_valid, imem_req_addr, imem_req_valid, RESET_PC);
        end
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (if_valid === 1'b1) found = 1'b1;
        end
        n_cmp++;
        if (!found || if_pc !== RESET_PC) begin
            n_bad++;
            $display("FAIL mid_rst_first: got found=%b pc=%h expected pc=%h", found, if_pc, RESET_PC);
        end
    endtask

    initial begin
        #200000;
        n_bad++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_free_run();
        test_decode_stall();
        test_redirect_outstanding();
        test_back_to_back();
        test_redirect_collide();
        test_req_stall();
        test_wrap_and_reset();
        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
